// File: rtl/dcache_assoc_datapath.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : dcache_assoc_datapath                                       |
// | Purpose  : Datapath of an N-way set-associative, write-back,           |
// |            write-allocate L1 data cache. Holds valid/dirty/tag/data    |
// |            arrays and a round-robin victim pointer per set, latches    |
// |            the target way at the start of a miss or flush, and moves   |
// |            lines word-serially to/from L2 under the line counter.      |
// | Ports    : clk/reset_n             clock, async active-low reset       |
// |            pipe_req_*              decoded pipeline request            |
// |            pipe_fetched_word       zero-extended load data             |
// |            l2_*                    L2 word address / fill / writeback  |
// |            flush_mode..counter     controller strobes                  |
// |            hit/miss/valid_dirty_bit/clflush_requested/target_way/      |
// |            counter_done            status back to the controller       |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module dcache_assoc_datapath #(
   parameter int LINE_SIZE = 32,
   parameter int OFS_SIZE  = 5,
   parameter int SET_SIZE  = 3,
   parameter int TAG_SIZE  = 24,
   parameter int NUM_SETS  = 8,
   parameter int NUM_WAYS  = 4,
   parameter int XLEN      = 32
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [OFS_SIZE-1:0]         pipe_req_ofs,
   input  logic [SET_SIZE-1:0]         pipe_req_set,
   input  logic [TAG_SIZE-1:0]         pipe_req_tag,
   input  logic [1:0]                  pipe_req_size,   // 0 BYTE, 1 HALF, 2 WORD
   input  logic [1:0]                  pipe_req_type,   // 0 LOAD, 1 STORE, 2 CLFLUSH
   input  logic                        pipe_req_valid,
   input  logic [XLEN-1:0]             pipe_word_to_store,
   output logic [XLEN-1:0]             pipe_fetched_word,
   output logic [XLEN-1:0]             l2_req_address,
   input  logic [XLEN-1:0]             l2_fetched_word,
   output logic [XLEN-1:0]             l2_word_to_store,
   input  logic                        flush_mode,
   input  logic                        load_mode,
   input  logic                        clear_selected_dirty_bit,
   input  logic                        clear_selected_valid_bit,
   input  logic                        finish_new_line_install,
   input  logic                        set_new_l2_block_address,
   input  logic                        use_dirty_tag_for_l2_block_address,
   input  logic                        reset_counter,
   input  logic                        decrement_counter,
   output logic                        counter_done,
   output logic                        hit,
   output logic                        miss,
   output logic                        valid_dirty_bit,
   output logic                        clflush_requested,
   output logic [$clog2(NUM_WAYS)-1:0] target_way
);

   localparam int WAY_W = $clog2(NUM_WAYS);
   localparam int WORDS = LINE_SIZE / 4;
   localparam int CNT_W = OFS_SIZE - 2;
   localparam int BLK_W = TAG_SIZE + SET_SIZE;

   localparam logic [1:0] SIZE_BYTE    = 2'd0;
   localparam logic [1:0] SIZE_HALF    = 2'd1;
   localparam logic [1:0] SIZE_WORD    = 2'd2;
   localparam logic [1:0] TYPE_STORE   = 2'd1;
   localparam logic [1:0] TYPE_CLFLUSH = 2'd2;

   logic [NUM_WAYS-1:0] valid    [NUM_SETS];
   logic [NUM_WAYS-1:0] dirty    [NUM_SETS];
   logic [WAY_W-1:0]    rr_ptr   [NUM_SETS];
   logic [TAG_SIZE-1:0] tag_arr  [NUM_SETS][NUM_WAYS];
   logic [XLEN-1:0]     data_arr [NUM_SETS][NUM_WAYS][WORDS];
   logic [CNT_W-1:0]    counter;
   logic [BLK_W-1:0]    l2_block_address;

   logic [NUM_WAYS-1:0] way_hit;
   logic [WAY_W-1:0]    hit_way;
   logic [WAY_W-1:0]    free_way;
   logic [WAY_W-1:0]    cand_way;
   logic [WAY_W-1:0]    rw_way;
   logic [CNT_W-1:0]    word_sel;
   logic [1:0]          eff_size;
   logic [1:0]          byte_sel;
   logic [XLEN-1:0]     raw_word;
   logic [7:0]          byte_val;
   logic [15:0]         half_val;
   logic [3:0]          byte_en;
   logic [XLEN-1:0]     store_data;
   logic                any_hit;
   logic                is_clflush;
   logic                serial;
   logic                store_hit;

   // ---------------- lookup and victim choice ----------------
   always_comb begin
      way_hit  = '0;
      hit_way  = '0;
      free_way = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         way_hit[w] = valid[pipe_req_set][w] && (tag_arr[pipe_req_set][w] == pipe_req_tag);
         if (way_hit[w]) hit_way = hit_way | WAY_W'(w);
      end
      // Scan downwards so the lowest-index invalid way wins.
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (!valid[pipe_req_set][w]) free_way = WAY_W'(w);
      end
   end

   assign any_hit           = |way_hit;
   assign hit               = pipe_req_valid & any_hit;
   assign miss              = pipe_req_valid & ~any_hit;
   assign is_clflush        = (pipe_req_type == TYPE_CLFLUSH);
   assign clflush_requested = pipe_req_valid & is_clflush;

   // hit_way is already 0 when nothing hits, which is the CLFLUSH-miss choice.
   assign cand_way = is_clflush                   ? hit_way  :
                     (~&valid[pipe_req_set])      ? free_way : rr_ptr[pipe_req_set];
   assign valid_dirty_bit = valid[pipe_req_set][cand_way] & dirty[pipe_req_set][cand_way];

   // ---------------- read path ----------------
   assign serial   = flush_mode | load_mode;
   assign rw_way   = serial ? target_way : hit_way;
   assign word_sel = serial ? counter : pipe_req_ofs[OFS_SIZE-1:2];
   assign eff_size = serial ? SIZE_WORD : pipe_req_size;
   assign byte_sel = pipe_req_ofs[1:0];
   assign raw_word = data_arr[pipe_req_set][rw_way][word_sel];
   assign byte_val = raw_word[{byte_sel, 3'b000} +: 8];
   // Halfwords are naturally aligned: only the upper offset bit picks the lane pair.
   assign half_val = raw_word[{byte_sel[1], 4'b0000} +: 16];

   always_comb begin
      case (eff_size)
         SIZE_BYTE: pipe_fetched_word = {{(XLEN-8){1'b0}}, byte_val};
         SIZE_HALF: pipe_fetched_word = {{(XLEN-16){1'b0}}, half_val};
         default:   pipe_fetched_word = raw_word;
      endcase
   end

   assign l2_word_to_store = raw_word;
   assign l2_req_address   = {l2_block_address, counter, 2'b00};
   assign counter_done     = (counter == '0);

   // ---------------- store lanes ----------------
   assign store_hit = hit & (pipe_req_type == TYPE_STORE) & ~serial;

   always_comb begin
      case (pipe_req_size)
         SIZE_BYTE: begin
            byte_en    = 4'b0001 << byte_sel;
            store_data = {4{pipe_word_to_store[7:0]}};
         end
         SIZE_HALF: begin
            byte_en    = byte_sel[1] ? 4'b1100 : 4'b0011;
            store_data = {2{pipe_word_to_store[15:0]}};
         end
         default: begin
            byte_en    = 4'b1111;
            store_data = pipe_word_to_store;
         end
      endcase
   end

   // ---------------- control state and metadata ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         counter          <= '1;
         target_way       <= '0;
         l2_block_address <= '0;
         for (int s = 0; s < NUM_SETS; s++) begin
            valid[s]  <= '0;
            dirty[s]  <= '0;
            rr_ptr[s] <= '0;
         end
      end else begin
         if (reset_counter)          counter <= '1;
         else if (decrement_counter) counter <= counter - 1'b1;

         if (set_new_l2_block_address) begin
            target_way       <= cand_way;
            l2_block_address <= {use_dirty_tag_for_l2_block_address ?
                                 tag_arr[pipe_req_set][cand_way] : pipe_req_tag,
                                 pipe_req_set};
         end

         if (clear_selected_dirty_bit) dirty[pipe_req_set][target_way] <= 1'b0;
         else if (store_hit)           dirty[pipe_req_set][hit_way]    <= 1'b1;

         if (clear_selected_valid_bit) begin
            valid[pipe_req_set][target_way] <= 1'b0;
         end else if (finish_new_line_install) begin
            valid[pipe_req_set][target_way] <= 1'b1;
            // NUM_WAYS is a power of two, so the increment wraps by itself.
            rr_ptr[pipe_req_set]            <= target_way + 1'b1;
         end
      end
   end

   // Tag and data storage carry no reset.
   always_ff @(posedge clk) begin
      if (finish_new_line_install && !clear_selected_valid_bit)
         tag_arr[pipe_req_set][target_way] <= pipe_req_tag;

      if (load_mode) begin
         data_arr[pipe_req_set][target_way][counter] <= l2_fetched_word;
      end else if (store_hit) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b])
               data_arr[pipe_req_set][hit_way][pipe_req_ofs[OFS_SIZE-1:2]][b*8 +: 8]
                  <= store_data[b*8 +: 8];
         end
      end
   end

   a_single_hit: assert property (@(posedge clk) disable iff (!reset_n)
                                  pipe_req_valid |-> $onehot0(way_hit));

endmodule
`default_nettype wire

// File: tb/tb_dcache_assoc_datapath.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_dcache_assoc_datapath                                    |
// | Purpose  : Directed scoreboard bench for dcache_assoc_datapath. The    |
// |            stimulus pushes expected values into queues; a monitor on   |
// |            the falling edge pops and compares them.                    |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_dcache_assoc_datapath;

   localparam int S_HIT = 0, S_MISS = 1, S_VD = 2, S_TW = 3, S_RD = 4;
   localparam int S_L2A = 5, S_L2W = 6, S_DONE = 7, S_CLF = 8;
   localparam logic [1:0] BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2;
   localparam logic [1:0] LOAD = 2'd0, STORE = 2'd1, CLFLUSH = 2'd2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [4:0]  pipe_req_ofs;
   logic [2:0]  pipe_req_set;
   logic [23:0] pipe_req_tag;
   logic [1:0]  pipe_req_size, pipe_req_type;
   logic        pipe_req_valid;
   logic [31:0] pipe_word_to_store, pipe_fetched_word;
   logic [31:0] l2_req_address, l2_fetched_word, l2_word_to_store;
   logic        flush_mode, load_mode, clear_selected_dirty_bit, clear_selected_valid_bit;
   logic        finish_new_line_install, set_new_l2_block_address;
   logic        use_dirty_tag_for_l2_block_address, reset_counter, decrement_counter;
   logic        counter_done, hit, miss, valid_dirty_bit, clflush_requested;
   logic [1:0]  target_way;

   always #5 clk = ~clk;

   dcache_assoc_datapath dut (
      .clk(clk), .reset_n(reset_n),
      .pipe_req_ofs(pipe_req_ofs), .pipe_req_set(pipe_req_set), .pipe_req_tag(pipe_req_tag),
      .pipe_req_size(pipe_req_size), .pipe_req_type(pipe_req_type),
      .pipe_req_valid(pipe_req_valid), .pipe_word_to_store(pipe_word_to_store),
      .pipe_fetched_word(pipe_fetched_word), .l2_req_address(l2_req_address),
      .l2_fetched_word(l2_fetched_word), .l2_word_to_store(l2_word_to_store),
      .flush_mode(flush_mode), .load_mode(load_mode),
      .clear_selected_dirty_bit(clear_selected_dirty_bit),
      .clear_selected_valid_bit(clear_selected_valid_bit),
      .finish_new_line_install(finish_new_line_install),
      .set_new_l2_block_address(set_new_l2_block_address),
      .use_dirty_tag_for_l2_block_address(use_dirty_tag_for_l2_block_address),
      .reset_counter(reset_counter), .decrement_counter(decrement_counter),
      .counter_done(counter_done), .hit(hit), .miss(miss),
      .valid_dirty_bit(valid_dirty_bit), .clflush_requested(clflush_requested),
      .target_way(target_way)
   );

   string       q_name[$];
   int          q_sig[$];
   logic [31:0] q_exp[$];
   int          checks   = 0;
   int          failures = 0;

   function automatic logic [31:0] actual(input int s);
      case (s)
         S_HIT:   return {31'd0, hit};
         S_MISS:  return {31'd0, miss};
         S_VD:    return {31'd0, valid_dirty_bit};
         S_TW:    return {30'd0, target_way};
         S_RD:    return pipe_fetched_word;
         S_L2A:   return l2_req_address;
         S_L2W:   return l2_word_to_store;
         S_DONE:  return {31'd0, counter_done};
         default: return {31'd0, clflush_requested};
      endcase
   endfunction

   // Monitor: every falling edge, drain all expectations queued since the last edge.
   always @(negedge clk) begin
      while (q_sig.size() > 0) begin
         string       n;
         int          s;
         logic [31:0] e;
         logic [31:0] a;
         n = q_name.pop_front();
         s = q_sig.pop_front();
         e = q_exp.pop_front();
         a = actual(s);
         checks++;
         if (a !== e) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", n, a, e);
         end
      end
   end

   task automatic chk(input string n, input int s, input logic [31:0] v);
      q_name.push_back(n);
      q_sig.push_back(s);
      q_exp.push_back(v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush_mode = 0; load_mode = 0; clear_selected_dirty_bit = 0;
      clear_selected_valid_bit = 0; finish_new_line_install = 0;
      set_new_l2_block_address = 0; use_dirty_tag_for_l2_block_address = 0;
      reset_counter = 0; decrement_counter = 0; l2_fetched_word = '0;
   endtask

   task automatic req(input logic [1:0] ty, input logic [1:0] sz, input logic [4:0] ofs,
                      input logic [23:0] tg, input logic [31:0] wd);
      pipe_req_valid = 1; pipe_req_type = ty; pipe_req_size = sz;
      pipe_req_ofs = ofs; pipe_req_set = 3'd2; pipe_req_tag = tg; pipe_word_to_store = wd;
   endtask

   // Miss, latch way, fill 8 words (word k = base+k, counter walks 7..0), install.
   task automatic fill(input logic [23:0] tg, input logic [31:0] base, input logic [1:0] way);
      req(LOAD, WORD, 5'd0, tg, 32'd0);
      chk("fill_miss", S_MISS, 1);
      set_new_l2_block_address = 1; tick(); set_new_l2_block_address = 0;
      chk("fill_way", S_TW, {30'd0, way});
      reset_counter = 1; tick(); reset_counter = 0;
      for (int k = 7; k >= 0; k--) begin
         load_mode = 1; decrement_counter = 1; l2_fetched_word = base + 32'(k);
         tick();
      end
      load_mode = 0; decrement_counter = 0;
      finish_new_line_install = 1; tick(); finish_new_line_install = 0;
      chk("fill_hit", S_HIT, 1);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] wexp;
      reset_n = 0; idle();
      pipe_req_valid = 0; pipe_req_type = LOAD; pipe_req_size = WORD;
      pipe_req_ofs = 0; pipe_req_set = 0; pipe_req_tag = 0; pipe_word_to_store = 0;
      tick();
      chk("rst_l2addr", S_L2A, 32'h0000_001C);
      chk("rst_done", S_DONE, 0);
      chk("rst_way", S_TW, 0);
      chk("rst_hit", S_HIT, 0);
      chk("rst_miss", S_MISS, 0);
      tick(); reset_n = 1; tick();

      // 1: first miss into set 2
      req(LOAD, WORD, 5'd0, 24'hA, 32'd0);
      chk("t1_miss", S_MISS, 1); chk("t1_hit", S_HIT, 0); chk("t1_vd", S_VD, 0);
      set_new_l2_block_address = 1; tick(); set_new_l2_block_address = 0;
      chk("t1_way", S_TW, 0); chk("t1_l2addr", S_L2A, 32'h0000_0A5C);
      tick();

      // 2: fill and read back
      fill(24'hA, 32'h100, 2'd0);
      req(LOAD, WORD, 5'h1C, 24'hA, 0); chk("t2_hit", S_HIT, 1); chk("t2_w7", S_RD, 32'h107); tick();
      req(LOAD, WORD, 5'h00, 24'hA, 0); chk("t2_w0", S_RD, 32'h100); tick();
      req(LOAD, BYTE, 5'h1D, 24'hA, 0); chk("t2_byte", S_RD, 32'h01); tick();
      req(LOAD, HALF, 5'h1C, 24'hA, 0); chk("t2_half", S_RD, 32'h107); tick();

      // clflush of the hit line frees way 0
      req(CLFLUSH, WORD, 5'd0, 24'hA, 0);
      chk("cf_req", S_CLF, 1); chk("cf_hit", S_HIT, 1);
      set_new_l2_block_address = 1; tick(); set_new_l2_block_address = 0;
      chk("cf_way", S_TW, 0);
      clear_selected_valid_bit = 1; tick(); clear_selected_valid_bit = 0;
      req(LOAD, WORD, 5'd0, 24'hA, 0); chk("cf_gone", S_MISS, 1); tick();

      // 3: fill all four ways, then round-robin replacement
      fill(24'd1, 32'h100, 2'd0);
      fill(24'd2, 32'h200, 2'd1);
      fill(24'd3, 32'h300, 2'd2);
      fill(24'd4, 32'h400, 2'd3);
      req(LOAD, WORD, 5'd0, 24'd5, 0); chk("t3_miss", S_MISS, 1); chk("t3_vd", S_VD, 0); tick();
      fill(24'd5, 32'h500, 2'd0);
      req(LOAD, WORD, 5'd0, 24'd6, 0);
      set_new_l2_block_address = 1; tick(); set_new_l2_block_address = 0;
      chk("t3_rr1", S_TW, 1); tick();
      req(LOAD, WORD, 5'h08, 24'd3, 0); chk("t3_rd", S_RD, 32'h302); tick();
      req(CLFLUSH, WORD, 5'd0, 24'h66, 0); chk("cf_miss", S_MISS, 1); chk("cf_req2", S_CLF, 1);
      set_new_l2_block_address = 1; tick(); set_new_l2_block_address = 0;
      chk("cf_miss_way", S_TW, 0); tick();

      // 4: stores on tag 2 (way 1) make it dirty
      req(STORE, BYTE, 5'h03, 24'd2, 32'h0000_00EF); chk("t4_sthit", S_HIT, 1); tick();
      req(LOAD, WORD, 5'h00, 24'd2, 0); chk("t4_word", S_RD, 32'hEF00_0200); tick();
      req(LOAD, BYTE, 5'h03, 24'd2, 0); chk("t4_byte", S_RD, 32'hEF); tick();
      req(STORE, HALF, 5'h06, 24'd2, 32'h1234_BEEF); tick();
      req(LOAD, WORD, 5'h04, 24'd2, 0); chk("t4_hword", S_RD, 32'hBEEF_0201); tick();
      req(LOAD, HALF, 5'h06, 24'd2, 0); chk("t4_half", S_RD, 32'hBEEF); tick();
      req(LOAD, WORD, 5'd0, 24'd7, 0); chk("t4_miss", S_MISS, 1); chk("t4_vd", S_VD, 1); tick();
      use_dirty_tag_for_l2_block_address = 1; set_new_l2_block_address = 1; tick();
      use_dirty_tag_for_l2_block_address = 0; set_new_l2_block_address = 0;
      chk("t4_way", S_TW, 1); chk("t4_oldtag", S_L2A, 32'h0000_025C); tick();

      // 5: serial writeback of way 1
      reset_counter = 1; tick(); reset_counter = 0;
      for (int k = 7; k >= 0; k--) begin
         wexp = (k == 0) ? 32'hEF00_0200 : (k == 1) ? 32'hBEEF_0201 : 32'h200 + 32'(k);
         flush_mode = 1;
         chk("wb_word", S_L2W, wexp);
         chk("wb_done", S_DONE, (k == 0) ? 32'd1 : 32'd0);
         chk("wb_addr", S_L2A, 32'h240 | 32'(k << 2));
         decrement_counter = 1; tick();
      end
      flush_mode = 0; decrement_counter = 0;
      clear_selected_dirty_bit = 1; tick(); clear_selected_dirty_bit = 0;
      chk("t5_clean", S_VD, 0); tick();
      fill(24'd7, 32'h700, 2'd1);
      req(LOAD, WORD, 5'h04, 24'd7, 0); chk("t5_rd", S_RD, 32'h701); tick();
      req(LOAD, WORD, 5'h00, 24'd2, 0); chk("t5_evicted", S_MISS, 1); tick();

      // 6: reset in the middle of a fill
      req(LOAD, WORD, 5'd0, 24'd8, 0);
      set_new_l2_block_address = 1; tick(); set_new_l2_block_address = 0;
      reset_counter = 1; tick(); reset_counter = 0;
      for (int k = 7; k >= 4; k--) begin
         load_mode = 1; decrement_counter = 1; l2_fetched_word = 32'h800 + 32'(k); tick();
      end
      load_mode = 0; decrement_counter = 0;
      chk("t6_pre_addr", S_L2A, 32'h0000_084C); chk("t6_pre_way", S_TW, 2); tick();
      reset_n = 0;
      req(LOAD, WORD, 5'd0, 24'd5, 0);
      chk("t6_addr", S_L2A, 32'h0000_001C); chk("t6_way", S_TW, 0);
      chk("t6_miss", S_MISS, 1); chk("t6_hit", S_HIT, 0);
      tick(); reset_n = 1; tick();
      req(LOAD, WORD, 5'd0, 24'd7, 0); chk("t6_miss7", S_MISS, 1); chk("t6_vd", S_VD, 0); tick();
      pipe_req_valid = 0; tick(); tick();

      if (q_sig.size() != 0) begin
         failures++;
         $display("FAIL drain actual=%0d required=0", q_sig.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
